// File: rtl/lfsr_prpg_param_pkg.sv
// Shared constants for the LFSR PRPG: feedback topology selectors and known-primitive tap masks.
package lfsr_prpg_param_pkg;

  localparam bit LFSR_FIB = 1'b0;
  localparam bit LFSR_GAL = 1'b1;

  // Fibonacci masks: bit k-1 set for each x^k term (constant term implicit).
  localparam logic [3:0]  POLY_FIB_4  = 4'b1100;
  localparam logic [7:0]  POLY_FIB_8  = 8'hB8;
  localparam logic [15:0] POLY_FIB_16 = 16'hB400;

  // Galois masks: bit i is the x^i coefficient (x^WIDTH implicit).
  localparam logic [3:0]  POLY_GAL_4  = 4'b1001;
  localparam logic [7:0]  POLY_GAL_8  = 8'h71;
  localparam logic [15:0] POLY_GAL_16 = 16'h6801;

endpackage

// File: rtl/lfsr_prpg_param_if.sv
// Control/status bundle of the LFSR PRPG; master drives controls, slave is the generator.
interface lfsr_prpg_param_if #(
  parameter int unsigned WIDTH = 8
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             taps_we;
  logic [WIDTH-1:0] taps_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             period_done;
  logic [WIDTH-1:0] period_len;
  logic             lockup;

  modport master (
    output en, load, seed_in, taps_we, taps_in,
    input  q, serial_out, period_done, period_len, lockup
  );

  modport slave (
    input  en, load, seed_in, taps_we, taps_in,
    output q, serial_out, period_done, period_len, lockup
  );

endinterface

// File: rtl/lfsr_prpg_param_step.sv
// One combinational LFSR step, Fibonacci or Galois; shared with the MISR block.
module lfsr_prpg_param_step
  import lfsr_prpg_param_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          GALOIS = LFSR_FIB
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] q_next_o
);

  if (GALOIS == LFSR_GAL) begin : g_galois
    assign q_next_o = {q_i[WIDTH-2:0], 1'b0} ^ (q_i[WIDTH-1] ? taps_i : '0);
  end else begin : g_fibonacci
    assign q_next_o = {q_i[WIDTH-2:0], ^(q_i & taps_i)};
  end

endmodule

// File: rtl/lfsr_prpg_param.sv
// Parametrised LFSR pattern generator with run-time seed/tap reload, period measurement and
// automatic recovery from the all-zero state.
module lfsr_prpg_param
  import lfsr_prpg_param_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(1),
  parameter bit               GALOIS       = LFSR_FIB
) (
  input logic               clk,
  input logic               rst,
  lfsr_prpg_param_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] SEED_RST = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] cnt_inc;

  lfsr_prpg_param_step #(
    .WIDTH  (WIDTH),
    .GALOIS (GALOIS)
  ) u_step (
    .q_i      (q_q),
    .taps_i   (taps_q),
    .q_next_o (step_nxt)
  );

  // Priority load > taps_we > en; zero state is never allowed to persist.
  always_comb begin
    q_d      = q_q;
    taps_d   = taps_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    done_d   = 1'b0;
    lockup_d = 1'b0;
    cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + ONE;

    if (bus.load) begin
      cnt_d = '0;
      if (bus.seed_in == '0) begin
        q_d      = ONE;
        start_d  = ONE;
        lockup_d = 1'b1;
      end else begin
        q_d     = bus.seed_in;
        start_d = bus.seed_in;
      end
    end else if (bus.taps_we) begin
      taps_d  = bus.taps_in;
      start_d = q_q;
      cnt_d   = '0;
    end else if (bus.en) begin
      if (step_nxt == '0) begin
        q_d      = ONE;
        start_d  = ONE;
        cnt_d    = '0;
        lockup_d = 1'b1;
      end else begin
        q_d   = step_nxt;
        cnt_d = cnt_inc;
        if (step_nxt == start_q) begin
          done_d = 1'b1;
          len_d  = cnt_inc;
          cnt_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= SEED_RST;
      taps_q   <= DEFAULT_TAPS;
      start_q  <= SEED_RST;
      cnt_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      taps_q   <= taps_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus.q           = q_q;
  assign bus.serial_out  = q_q[WIDTH-1];
  assign bus.period_done = done_q;
  assign bus.period_len  = len_q;
  assign bus.lockup      = lockup_q;

endmodule
